// File: rtl/oport_arb.sv
// oport_arb: round-robin switch allocator for one output port, grant locked HEAD..TAIL,
// flit transfer gated by downstream readiness, with packet/flit statistics counters.
module oport_arb #(
  parameter int NPORT = 5,
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [NPORT-1:0]   req,
  input  logic [2*NPORT-1:0] ftype,
  input  logic               dn_rdy,
  output logic [NPORT-1:0]   grant,
  output logic [2:0]         sel,
  output logic               busy,
  output logic               fwd,
  output logic               err,
  output logic [CNTW-1:0]    pkt_cnt,
  output logic [CNTW-1:0]    flit_cnt
);
  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_TAIL = 2'd3;
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0]       state;
  logic [2:0]       ptr, winner, idx;
  logic [3:0]       sum;
  logic             found, first, head_err, none_err;
  logic [NPORT-1:0] cand;
  logic [1:0]       cur;
  always_comb begin
    for (int i = 0; i < NPORT; i++) cand[i] = req[i] && ftype[2*i +: 2] == T_HEAD;
  end
  // scan ptr+1, ptr+2, ... so the port that just finished ranks last
  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    sum    = 4'd0;
    idx    = 3'd0;
    for (int k = 1; k <= NPORT; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      idx = sum >= 4'(NPORT) ? 3'(sum - 4'(NPORT)) : sum[2:0];
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end
  assign busy     = state;
  assign cur      = ftype[{sel, 1'b0} +: 2];
  assign fwd      = busy & req[sel] & dn_rdy;
  assign head_err = fwd && cur == T_HEAD && !first;
  assign none_err = busy && req[sel] && cur == T_NONE;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= 3'd0;
      ptr      <= 3'(NPORT - 1);
      first    <= 1'b0;
      err      <= 1'b0;
      pkt_cnt  <= '0;
      flit_cnt <= '0;
    end else begin
      err <= head_err | none_err;
      if (fwd) flit_cnt <= flit_cnt + CNTW'(1);
      if (state == IDLE) begin
        if (found) begin
          state <= LOCKED;
          grant <= NPORT'(1) << winner;
          sel   <= winner;
          first <= 1'b1;
        end
      end else if (fwd) begin
        first <= 1'b0;
        if (cur == T_TAIL) begin
          pkt_cnt <= pkt_cnt + CNTW'(1);
          ptr     <= sel;
          state   <= IDLE;
          grant   <= '0;
          sel     <= 3'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_oport_arb.sv
// tb_oport_arb: scenario tasks for oport_arb with a grant-order scoreboard queue.
module tb_oport_arb;
  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_DATA = 2'd2;
  localparam logic [1:0] T_TAIL = 2'd3;
  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [4:0]  req = '0;
  logic [9:0]  ftype = '0;
  logic        dn_rdy = 1'b0;
  logic [4:0]  grant;
  logic [2:0]  sel;
  logic        busy, fwd, err;
  logic [15:0] pkt_cnt, flit_cnt;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];
  int obs_q[$];
  int rise_q[$];
  logic [4:0] gnt_q[$];
  int pkt_left[5];
  int plen[5];
  int fidx[5];
  int t_errs;

  oport_arb #(.NPORT(5), .CNTW(16)) dut (
    .clk(clk), .rst_(rst_), .req(req), .ftype(ftype), .dn_rdy(dn_rdy),
    .grant(grant), .sel(sel), .busy(busy), .fwd(fwd), .err(err),
    .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_port(input int p, input logic r, input logic [1:0] t);
    req[p] = r;
    ftype[2*p +: 2] = t;
  endtask

  task automatic apply_reset();
    rst_ = 1'b0;
    req = '0;
    ftype = '0;
    dn_rdy = 1'b0;
    exp_q.delete();
    obs_q.delete();
    rise_q.delete();
    gnt_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  function automatic int left_sum();
    int s = 0;
    for (int p = 0; p < 5; p++) s += pkt_left[p];
    return s;
  endfunction

  // behavioural sources: each port walks its packets, advancing only on its own handshake
  task automatic run_traffic(input int max_cyc, output bit timed_out);
    int c = 0;
    int s;
    logic pb = 1'b0;
    t_errs = 0;
    while (left_sum() > 0 && c < max_cyc) begin
      @(posedge clk); #1;
      dn_rdy = 1'b1;
      for (int p = 0; p < 5; p++)
        if (pkt_left[p] > 0) set_port(p, 1'b1, fidx[p] == 0 ? T_HEAD : fidx[p] == plen[p]-1 ? T_TAIL : T_DATA);
        else set_port(p, 1'b0, T_NONE);
      @(negedge clk);
      if (busy && !pb) begin
        obs_q.push_back(int'(sel));
        gnt_q.push_back(grant);
        rise_q.push_back(c);
      end
      pb = busy;
      if (fwd) begin
        s = int'(sel);
        fidx[s]++;
        if (fidx[s] == plen[s]) begin
          fidx[s] = 0;
          pkt_left[s]--;
        end
      end
      if (err) t_errs++;
      c++;
    end
    timed_out = left_sum() > 0;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    req = '1;
    ftype = {5{T_HEAD}};
    dn_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (grant !== 5'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected 00000", grant); end
    n_tests++; if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    n_tests++; if (busy !== 1'b0 || fwd !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got busy=%b fwd=%b err=%b expected 0 0 0", busy, fwd, err); end
    n_tests++; if (pkt_cnt !== 16'd0 || flit_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got pkt=%0d flit=%0d expected 0 0", pkt_cnt, flit_cnt); end
    rst_ = 1'b1;
    @(negedge clk);
    n_tests++; if (grant !== 5'b00001 || sel !== 3'd0) begin n_fail++; $display("FAIL reset_prio: got grant=%b sel=%0d expected 00001 0", grant, sel); end
    apply_reset();
  endtask

  task automatic test_single_packet();
    int nf = 0;
    int e;
    logic [4:0] eg;
    apply_reset();
    @(posedge clk); #1;
    dn_rdy = 1'b1;
    set_port(2, 1'b1, T_HEAD);
    exp_q.push_back(2);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || fwd !== 1'b0) begin n_fail++; $display("FAIL single_arb_cycle: got busy=%b fwd=%b expected 0 0", busy, fwd); end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      set_port(2, 1'b1, k == 1 ? T_HEAD : k == 6 ? T_TAIL : T_DATA);
      @(negedge clk);
      if (k == 1) begin
        n_tests++;
        if (exp_q.size() == 0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant_rise: got busy=%b expected 1", busy); end
        else begin
          e = exp_q.pop_front();
          eg = 5'b1 << e;
          if (sel !== 3'(e) || grant !== eg) begin n_fail++; $display("FAIL single_grant: got sel=%0d grant=%b expected %0d %b", sel, grant, e, eg); end
        end
      end
      if (fwd) nf++;
      n_tests++; if (grant !== 5'b00100) begin n_fail++; $display("FAIL single_hold c%0d: got %b expected 00100", k, grant); end
    end
    @(posedge clk); #1;
    set_port(2, 1'b0, T_NONE);
    @(negedge clk);
    n_tests++; if (nf != 6) begin n_fail++; $display("FAIL single_fwd_cycles: got %0d expected 6", nf); end
    n_tests++; if (busy !== 1'b0 || grant !== 5'b0) begin n_fail++; $display("FAIL single_release: got busy=%b grant=%b expected 0 00000", busy, grant); end
    n_tests++; if (pkt_cnt !== 16'd1 || flit_cnt !== 16'd6) begin n_fail++; $display("FAIL single_cnt: got pkt=%0d flit=%0d expected 1 6", pkt_cnt, flit_cnt); end
  endtask

  task automatic test_round_robin();
    bit to;
    int e, o, r, pr;
    logic [4:0] g, eg;
    apply_reset();
    for (int p = 0; p < 5; p++) begin
      plen[p] = 6;
      fidx[p] = 0;
      pkt_left[p] = (p == 0) ? 2 : 1;
    end
    exp_q = '{0, 1, 2, 3, 4, 0};
    run_traffic(200, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL rr_timeout: got %0d packets left expected 0", left_sum()); end
    n_tests++; if (obs_q.size() != 6) begin n_fail++; $display("FAIL rr_grants: got %0d expected 6", obs_q.size()); end
    pr = -1;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      g = gnt_q.pop_front();
      r = rise_q.pop_front();
      eg = 5'b1 << e;
      n_tests++; if (o != e || g !== eg) begin n_fail++; $display("FAIL rr_order: got sel=%0d grant=%b expected %0d %b", o, g, e, eg); end
      if (pr >= 0) begin
        n_tests++; if (r - pr != 7) begin n_fail++; $display("FAIL rr_gap: got %0d expected 7", r - pr); end
      end
      pr = r;
    end
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    n_tests++; if (pkt_cnt !== 16'd6 || flit_cnt !== 16'd36) begin n_fail++; $display("FAIL rr_cnt: got pkt=%0d flit=%0d expected 6 36", pkt_cnt, flit_cnt); end
    n_tests++; if (t_errs != 0) begin n_fail++; $display("FAIL rr_err: got %0d expected 0", t_errs); end
  endtask

  task automatic test_flow_control();
    int idx = 0;
    int nf = 0;
    int e;
    bit done = 0;
    logic r, ef;
    apply_reset();
    @(posedge clk); #1;
    dn_rdy = 1'b0;
    set_port(1, 1'b1, T_HEAD);
    exp_q.push_back(1);
    @(negedge clk);
    for (int c = 1; c <= 20 && !done; c++) begin
      @(posedge clk); #1;
      dn_rdy = (c <= 4) ? (c % 2 == 1) : 1'b1;
      r = !(c == 3 || c == 4);
      set_port(1, r, !r ? T_NONE : idx == 0 ? T_HEAD : idx == 3 ? T_TAIL : T_DATA);
      @(negedge clk);
      if (c == 1) begin
        e = exp_q.pop_front();
        n_tests++; if (sel !== 3'(e) || busy !== 1'b1) begin n_fail++; $display("FAIL fc_grant: got sel=%0d busy=%b expected %0d 1", sel, busy, e); end
      end
      ef = r && dn_rdy;
      n_tests++; if (grant !== 5'b00010) begin n_fail++; $display("FAIL fc_hold c%0d: got %b expected 00010", c, grant); end
      n_tests++; if (fwd !== ef) begin n_fail++; $display("FAIL fc_fwd c%0d: got %b expected %b", c, fwd, ef); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL fc_err c%0d: got %b expected 0", c, err); end
      if (fwd) nf++;
      if (ef) begin
        if (idx == 3) done = 1;
        idx++;
      end
    end
    @(posedge clk); #1;
    set_port(1, 1'b0, T_NONE);
    @(negedge clk);
    n_tests++; if (!done || nf != 4) begin n_fail++; $display("FAIL fc_fwd_total: got %0d expected 4", nf); end
    n_tests++; if (flit_cnt !== 16'd4 || busy !== 1'b0) begin n_fail++; $display("FAIL fc_end: got flit=%0d busy=%b expected 4 0", flit_cnt, busy); end
  endtask

  task automatic test_head_error();
    logic ee;
    apply_reset();
    @(posedge clk); #1;
    dn_rdy = 1'b1;
    set_port(3, 1'b1, T_HEAD);
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      set_port(3, 1'b1, (c == 1 || c == 3) ? T_HEAD : c == 5 ? T_TAIL : T_DATA);
      @(negedge clk);
      ee = (c == 4);
      n_tests++; if (err !== ee) begin n_fail++; $display("FAIL herr_pulse c%0d: got %b expected %b", c, err, ee); end
      n_tests++; if (busy !== 1'b1 || grant !== 5'b01000) begin n_fail++; $display("FAIL herr_lock c%0d: got busy=%b grant=%b expected 1 01000", c, busy, grant); end
    end
    @(posedge clk); #1;
    set_port(3, 1'b0, T_NONE);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL herr_release: got busy=%b err=%b expected 0 0", busy, err); end
    n_tests++; if (flit_cnt !== 16'd5 || pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL herr_cnt: got pkt=%0d flit=%0d expected 1 5", pkt_cnt, flit_cnt); end
  endtask

  task automatic test_none_error();
    logic ee;
    apply_reset();
    @(posedge clk); #1;
    dn_rdy = 1'b1;
    set_port(2, 1'b1, T_HEAD);
    @(negedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      set_port(2, 1'b1, c == 1 ? T_HEAD : c == 2 ? T_NONE : T_TAIL);
      @(negedge clk);
      ee = (c == 3);
      n_tests++; if (err !== ee) begin n_fail++; $display("FAIL nerr_pulse c%0d: got %b expected %b", c, err, ee); end
    end
    @(posedge clk); #1;
    set_port(2, 1'b0, T_NONE);
    @(negedge clk);
    n_tests++; if (err !== 1'b0 || busy !== 1'b0 || flit_cnt !== 16'd3) begin n_fail++; $display("FAIL nerr_end: got err=%b busy=%b flit=%0d expected 0 0 3", err, busy, flit_cnt); end
  endtask

  task automatic test_reset_midpacket();
    int e;
    apply_reset();
    @(posedge clk); #1;
    dn_rdy = 1'b1;
    set_port(4, 1'b1, T_HEAD);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      set_port(4, 1'b1, c == 1 ? T_HEAD : T_DATA);
    end
    @(negedge clk);
    n_tests++; if (busy !== 1'b1 || flit_cnt !== 16'd2) begin n_fail++; $display("FAIL mid_pre: got busy=%b flit=%0d expected 1 2", busy, flit_cnt); end
    #1 rst_ = 1'b0;
    #1;
    n_tests++; if (grant !== 5'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async: got grant=%b busy=%b expected 00000 0", grant, busy); end
    n_tests++; if (flit_cnt !== 16'd0 || pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_cnt: got pkt=%0d flit=%0d expected 0 0", pkt_cnt, flit_cnt); end
    req = '0;
    ftype = '0;
    @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    set_port(0, 1'b1, T_HEAD);
    set_port(4, 1'b1, T_HEAD);
    exp_q.push_back(0);
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++; if (sel !== 3'(e) || grant !== 5'b00001) begin n_fail++; $display("FAIL mid_prio: got sel=%0d grant=%b expected %0d 00001", sel, grant, e); end
  endtask

  task automatic test_wrap();
    int errs = 0;
    int nofwd = 0;
    apply_reset();
    @(posedge clk); #1;
    dn_rdy = 1'b1;
    set_port(0, 1'b1, T_HEAD);
    @(negedge clk);
    for (int c = 1; c <= 65536; c++) begin
      @(posedge clk); #1;
      set_port(0, 1'b1, c == 1 ? T_HEAD : c == 65536 ? T_TAIL : T_DATA);
      @(negedge clk);
      if (err) errs++;
      if (!fwd) nofwd++;
      if (c == 65536) begin
        n_tests++; if (flit_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre: got %0d expected 65535", flit_cnt); end
      end
    end
    @(posedge clk); #1;
    set_port(0, 1'b0, T_NONE);
    @(negedge clk);
    n_tests++; if (flit_cnt !== 16'd0 || pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL wrap_cnt: got pkt=%0d flit=%0d expected 1 0", pkt_cnt, flit_cnt); end
    n_tests++; if (errs != 0 || err !== 1'b0) begin n_fail++; $display("FAIL wrap_err: got %0d expected 0", errs); end
    n_tests++; if (nofwd != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL wrap_stall: got %0d stalls busy=%b expected 0 0", nofwd, busy); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_flow_control();
    test_head_error();
    test_none_error();
    test_reset_midpacket();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/oport_arb.md
# oport_arb

Per-output-port switch allocator for the 5-port router. It arbitrates among the five input ports for a single output port using round-robin, and locks the grant for a whole packet, from HEAD flit through TAIL flit. It gates flit transfer on downstream readiness and keeps packet and flit counters for the energy/throughput benches. One instance sits in front of each output port's crossbar mux.

## Interface
Parameters:
- NPORT, 5, number of requesting input ports; fixed at 5 for the mesh router.
- CNTW, 16, width of the statistics counters.

Ports:
- clk  in  1  router clock; all state updates on the rising edge.
- rst_  in  1  asynchronous, active-low reset.
- req  in  NPORT  bit i high: input port i holds a valid flit routed to this output.
- ftype  in  2*NPORT  flit type of port i at bits [2i+1:2i]. Encodings are the shared TYPE_NONE/HEAD/DATA/TAIL macros.
- dn_rdy  in  1  downstream can accept one flit this cycle (credit/ack of the target VC).
- grant  out  NPORT  one-hot owner of the output; registered.
- sel  out  3  binary index of the owner; crossbar select; registered.
- busy  out  1  output locked to a packet; registered.
- fwd  out  1  a flit moves this cycle; combinational: busy & req[sel] & dn_rdy.
- err  out  1  one-cycle registered pulse on a protocol violation.
- pkt_cnt  out  CNTW  packets completed (TAIL forwarded), wraps.
- flit_cnt  out  CNTW  flits forwarded, wraps.

## Operation
- Two states:
  - IDLE: grant=0, busy=0.
  - LOCKED: grant one-hot, busy=1.
- IDLE: the candidate set is the ports i with req[i]=1 and ftype[i]=HEAD. Ports presenting DATA/TAIL/NONE are ignored.
  - Non-empty set: pick the first candidate scanning ptr+1, ptr+2, … modulo 5.
  - Next edge: grant ← onehot(winner), sel ← winner, state ← LOCKED.
  - Arbitration does not depend on dn_rdy.
- LOCKED: only req[sel] matters; other ports wait.
  - fwd asserts whenever req[sel] & dn_rdy. Each fwd increments flit_cnt.
  - fwd with ftype[sel]=TAIL: pkt_cnt+1, ptr ← sel, state ← IDLE, grant/sel/busy cleared next edge.
  - Owner drops req mid-packet (bubble): stay LOCKED, no fwd, no counting.
  - dn_rdy low: hold; no flit consumed.
- ptr is updated only on packet completion, so the finishing port has lowest priority next round.
- err pulses for one cycle after either violation:
  - fwd with ftype[sel]=HEAD while locked and not on the packet's first flit.
  - ftype[sel]=NONE with req[sel]=1 while locked.
- An err does not change state; a HEAD violation is forwarded and counted.
- Counters wrap from 2^CNTW−1 to 0 with no saturation.

## Timing
- Reset (async assert, sync deassert by the system): state=IDLE, grant=0, sel=0, busy=0, err=0, pkt_cnt=0, flit_cnt=0, ptr=4 (port 0 highest priority after reset).
- Reset mid-packet drops the lock immediately. Counters are not preserved.
- Latency:
  - HEAD presented at cycle t in IDLE → grant/busy at t+1.
  - HEAD forwarded at t+1 if dn_rdy.
- Packet of N flits with dn_rdy=1 and no bubbles: fwd at t+1..t+N, busy falls at t+N+1. The earliest next grant is at t+N+2 (one idle arbitration cycle between packets).
- A HEAD arriving in the same cycle the TAIL is forwarded is not considered until the IDLE cycle.
- Simultaneous HEADs: exactly one winner per arbitration. Losers keep req asserted and win in later rounds. A port with continuous traffic waits at most 4 packets.

## Test plan
- Reset, then HEAD on port 2 only, 4 DATA + TAIL, dn_rdy=1 → grant=5'b00100 and sel=2 at t+1; fwd for 6 cycles; pkt_cnt=1, flit_cnt=6; busy=0 at t+7.
- All five ports hold HEAD continuously, 6-flit packets → grant order 0,1,2,3,4,0; pkt_cnt=6 after six packets; no port granted twice before all others are served.
- Locked on port 1, dn_rdy toggles 1,0,1,0 and owner inserts a 2-cycle req bubble → fwd only on cycles with req & dn_rdy; flit_cnt equals packet length; grant is held throughout.
- Locked on port 3, owner presents HEAD on its 3rd flit → err pulses one cycle; still LOCKED; released only on the TAIL.
- Assert rst_=0 mid-packet while locked on port 4 → grant=0, busy=0, counters=0 immediately. After release, simultaneous HEADs on ports 0 and 4 → port 0 wins.
- Preload flit_cnt near wrap by running 65536 flits → flit_cnt rolls to 0 with no err.
